// File: rtl/la_capture_core.sv
// la_capture_core: parametrised logic-analyser capture engine (prescaler, mask/value trigger, pre-trigger window, circular buffer, oldest-first readout)
// Ports: clk_i/rst_i (sync active-high), data_i probes, div_i prescaler (sample every div_i+1 cycles),
//   arm_i/abort_i control, trig_mask_i/trig_value_i/trig_edge_i trigger setup, pretrig_i pre-trigger depth,
//   busy_o/triggered_o/done_o/state_o status, rd_valid_o/rd_ready_i/rd_data_o/rd_last_o readout stream.
// Optional: define LA_TIMESTAMP_EN to store a TS_W-bit strobe count with each sample (rd_data_o = {timestamp, data}).
module la_capture_core #(
  parameter int CH_W       = 10,
  parameter int DEPTH_LOG2 = 10,
  parameter int DIV_W      = 13,
  parameter int TS_W       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [CH_W-1:0]       data_i,
  input  logic [DIV_W-1:0]      div_i,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic [CH_W-1:0]       trig_mask_i,
  input  logic [CH_W-1:0]       trig_value_i,
  input  logic                  trig_edge_i,
  input  logic [DEPTH_LOG2-1:0] pretrig_i,
  output logic                  busy_o,
  output logic                  triggered_o,
  output logic                  done_o,
  output logic [2:0]            state_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
`ifdef LA_TIMESTAMP_EN
  output logic [CH_W+TS_W-1:0]  rd_data_o,
`else
  output logic [CH_W-1:0]       rd_data_o,
`endif
  output logic                  rd_last_o
);
`ifdef LA_TIMESTAMP_EN
  localparam int MW = CH_W + TS_W;
`else
  localparam int MW = CH_W;
`endif
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] ONE = 1;
  if (CH_W < 1 || DEPTH_LOG2 < 1 || DIV_W < 1 || TS_W < 1) begin : g_param_check
    $error("la_capture_core: all parameters must be positive");
  end
  typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, WAIT = 3'd2, POST = 3'd3, READ = 3'd4} state_t;
  state_t state, state_n;
  logic [DIV_W-1:0] cnt;
  logic strobe, arm, match, hit, fire, sampling;
  logic [CH_W-1:0] mask_q, value_q;
  logic edge_q, prev_match;
  logic [DEPTH_LOG2-1:0] pretrig_q, wr_ptr, rd_ptr, remaining, rd_cnt, raddr;
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] wdata;
  // >= rather than == so a live decrease of div_i below the running count restarts at once
  assign strobe = cnt >= div_i;
  assign arm = arm_i && !abort_i && state == IDLE;
  assign match = ((data_i ^ value_q) & mask_q) == '0;
  assign hit = strobe && match && (!edge_q || !prev_match);
  assign sampling = state == PRE || state == WAIT || state == POST;
  assign fire = rd_valid_o && rd_ready_i && !abort_i;
  assign rd_last_o = rd_valid_o && rd_cnt == '1;
  assign busy_o = state != IDLE;
  assign state_o = state;
  // The output register re-reads the current address while stalled and prefetches the next one on a handshake
  assign raddr = fire ? rd_ptr + 1'b1 : rd_ptr;
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = arm_i ? (pretrig_i != '0 ? PRE : WAIT) : IDLE;
      PRE:     state_n = (strobe && wr_ptr == pretrig_q - ONE) ? WAIT : PRE;
      WAIT:    state_n = hit ? (pretrig_q == '1 ? READ : POST) : WAIT;
      POST:    state_n = (strobe && remaining == ONE) ? READ : POST;
      READ:    state_n = (fire && rd_last_o) ? IDLE : READ;
      default: state_n = IDLE;
    endcase
    if (abort_i) state_n = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_cnt <= '0;
      remaining <= '0;
      prev_match <= 1'b0;
      triggered_o <= 1'b0;
      done_o <= 1'b0;
      rd_valid_o <= 1'b0;
      mask_q <= '0;
      value_q <= '0;
      edge_q <= 1'b0;
      pretrig_q <= '0;
    end else begin
      cnt <= (arm || strobe) ? '0 : cnt + 1'b1;
      done_o <= fire && rd_last_o;
      rd_valid_o <= state == READ && !abort_i && !(fire && rd_last_o);
      if (arm) begin
        mask_q <= trig_mask_i;
        value_q <= trig_value_i;
        edge_q <= trig_edge_i;
        pretrig_q <= pretrig_i;
        wr_ptr <= '0;
        prev_match <= 1'b0;
        triggered_o <= 1'b0;
      end
      if (sampling && strobe) wr_ptr <= wr_ptr + 1'b1;
      if ((state == PRE || state == WAIT) && strobe) prev_match <= match;
      // The trigger sample lands at wr_ptr, so the window starts pretrig_q entries earlier
      if (state == WAIT && hit) begin
        triggered_o <= 1'b1;
        remaining <= ~pretrig_q;
        rd_ptr <= wr_ptr - pretrig_q;
        rd_cnt <= '0;
      end
      if (state == POST && strobe) remaining <= remaining - 1'b1;
      if (fire) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (abort_i || (fire && rd_last_o)) triggered_o <= 1'b0;
    end
  end
`ifdef LA_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  always_ff @(posedge clk_i) begin
    if (rst_i || arm) ts <= '0;
    else if (strobe && ts != '1) ts <= ts + 1'b1;
  end
  assign wdata = {ts, data_i};
`else
  assign wdata = data_i;
`endif
  always_ff @(posedge clk_i) begin
    if (sampling && strobe) mem[wr_ptr] <= wdata;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_o <= '0;
    else rd_data_o <= mem[raddr];
  end
endmodule
